// File: rtl/elevador_fila_pkg.sv
// Shared types for the elevator controller: state encoding, direction
// constants and the helper that splits pending calls into above/below.
package elevador_pkg;

    typedef enum logic [2:0] {
        PARADO   = 3'd0,
        SUBINDO  = 3'd1,
        DESCENDO = 3'd2,
        PORTA    = 3'd3,
        EMERG    = 3'd4
    } estado_t;

    localparam logic SOBE  = 1'b1;
    localparam logic DESCE = 1'b0;

    typedef struct packed {
        logic acima;
        logic abaixo;
    } pedidos_dir_t;

    // Reports whether any pending floor lies strictly above or strictly
    // below the current floor; floors at or beyond n_andares are ignored.
    function automatic pedidos_dir_t calc_direcoes(
        input logic [31:0] pendentes,
        input int          n_andares,
        input int          andar
    );
        pedidos_dir_t res;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n_andares && pendentes[i]) begin
                if (i > andar) res.acima  = 1'b1;
                if (i < andar) res.abaixo = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/elevador_fila_if.sv
// Bundle between the sensor/call-button side (master) and the
// controller (slave) that drives motor, door and status outputs.
//
// Request handshake: pedido_valido is a single-cycle strobe qualifying
// andar_pedido. There is no ready; the controller samples every strobe
// on the next rising edge and either latches it, turns it into a
// door-hold, or drops it (out of range, or during emergency).
interface elevador_fila_if #(
    parameter int N_ANDARES     = 5,
    parameter int LARGURA_ANDAR = $clog2(N_ANDARES)
);
    logic                     emergencia;
    logic [LARGURA_ANDAR-1:0] andar_atual;
    logic                     pedido_valido;
    logic [LARGURA_ANDAR-1:0] andar_pedido;
    logic                     motor_liga;
    logic                     motor_direcao;
    logic                     porta_aberta;
    logic [N_ANDARES-1:0]     pendentes;
    logic [2:0]               led_estado;

    modport master (
        output emergencia, andar_atual, pedido_valido, andar_pedido,
        input  motor_liga, motor_direcao, porta_aberta, pendentes, led_estado
    );

    modport slave (
        input  emergencia, andar_atual, pedido_valido, andar_pedido,
        output motor_liga, motor_direcao, porta_aberta, pendentes, led_estado
    );
endinterface

// File: rtl/elevador_fila_temporizador.sv
// Door-open down-counter. Loads TEMPO_PORTA-1 on load or reload and
// counts down to zero; expira is high while the count sits at zero.
module temporizador_porta #(
    parameter int TEMPO_PORTA = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_carga,
    input  logic i_recarga,
    output logic o_expira
);
    localparam int LARGURA = (TEMPO_PORTA > 1) ? $clog2(TEMPO_PORTA) : 1;
    localparam logic [LARGURA-1:0] VALOR_INICIAL = LARGURA'(TEMPO_PORTA - 1);

    logic [LARGURA-1:0] r_contagem;

    // Count register: (re)load has priority over the decrement.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_contagem <= '0;
        end else if (i_carga || i_recarga) begin
            r_contagem <= VALOR_INICIAL;
        end else if (r_contagem != '0) begin
            r_contagem <= r_contagem - LARGURA'(1);
        end
    end

    assign o_expira = (r_contagem == '0);
endmodule

// File: rtl/elevador_fila.sv
// Multi-floor elevator controller with latched calls, SCAN direction
// choice, timed door phase and latched emergency descent.
module elevador_fila
    import elevador_pkg::*;
#(
    parameter int N_ANDARES     = 5,
    parameter int LARGURA_ANDAR = $clog2(N_ANDARES),
    parameter int TEMPO_PORTA   = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    elevador_fila_if.slave bus
);
    estado_t              r_estado;
    estado_t              w_proximo;
    logic [N_ANDARES-1:0] r_pendentes;
    logic [N_ANDARES-1:0] w_pendentes_prox;
    logic                 r_dir_memo;

    logic [N_ANDARES-1:0] w_um_atual;
    logic [N_ANDARES-1:0] w_um_pedido;
    pedidos_dir_t         w_dirs;
    logic                 w_match;
    logic                 w_topo;
    logic                 w_base;
    logic                 w_pedido_ok;
    logic                 w_segura_porta;
    logic                 w_entra_porta;
    logic                 w_expira;

    // One-hot masks; a floor value beyond the last floor shifts out to zero,
    // so it never matches a pending bit.
    assign w_um_atual  = {{(N_ANDARES-1){1'b0}}, 1'b1} << bus.andar_atual;
    assign w_um_pedido = {{(N_ANDARES-1){1'b0}}, 1'b1} << bus.andar_pedido;

    assign w_dirs  = calc_direcoes(32'(r_pendentes), N_ANDARES, int'(bus.andar_atual));
    assign w_match = |(r_pendentes & w_um_atual);
    assign w_topo  = int'(bus.andar_atual) >= (N_ANDARES - 1);
    assign w_base  = (bus.andar_atual == LARGURA_ANDAR'(0));

    assign w_pedido_ok    = bus.pedido_valido && (int'(bus.andar_pedido) < N_ANDARES);
    assign w_segura_porta = (r_estado == PORTA) && bus.pedido_valido &&
                            (bus.andar_pedido == bus.andar_atual);
    assign w_entra_porta  = (w_proximo == PORTA) && (r_estado != PORTA);

    temporizador_porta #(.TEMPO_PORTA(TEMPO_PORTA)) u_temporizador (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_carga   (w_entra_porta),
        .i_recarga (w_segura_porta),
        .o_expira  (w_expira)
    );

    // Next-state: emergency overrides everything; otherwise SCAN rules.
    always_comb begin
        w_proximo = r_estado;
        if (bus.emergencia) begin
            w_proximo = EMERG;
        end else begin
            case (r_estado)
                PARADO: begin
                    if (w_match)                         w_proximo = PORTA;
                    else if (w_dirs.acima && w_dirs.abaixo)
                        w_proximo = (r_dir_memo == SOBE) ? SUBINDO : DESCENDO;
                    else if (w_dirs.acima)               w_proximo = SUBINDO;
                    else if (w_dirs.abaixo)              w_proximo = DESCENDO;
                end
                SUBINDO: begin
                    if (w_match)                         w_proximo = PORTA;
                    else if (!w_dirs.acima || w_topo)    w_proximo = PARADO;
                end
                DESCENDO: begin
                    if (w_match)                         w_proximo = PORTA;
                    else if (!w_dirs.abaixo || w_base)   w_proximo = PARADO;
                end
                PORTA: begin
                    if (w_expira && !w_segura_porta)     w_proximo = PARADO;
                end
                EMERG:   w_proximo = PARADO;
                default: w_proximo = PARADO;
            endcase
        end
    end

    // Request register update: set from a valid call, then clear on door
    // entry so a simultaneous set/clear of the same floor ends up cleared.
    always_comb begin
        w_pendentes_prox = r_pendentes;
        if (bus.emergencia) begin
            w_pendentes_prox = '0;
        end else begin
            if (w_pedido_ok && (r_estado != EMERG) && !w_segura_porta)
                w_pendentes_prox = w_pendentes_prox | w_um_pedido;
            if (w_entra_porta)
                w_pendentes_prox = w_pendentes_prox & ~w_um_atual;
        end
    end

    // State, request and remembered-direction registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado    <= PARADO;
            r_pendentes <= '0;
            r_dir_memo  <= SOBE;
        end else begin
            r_estado    <= w_proximo;
            r_pendentes <= w_pendentes_prox;
            if (w_proximo == SUBINDO && r_estado != SUBINDO)
                r_dir_memo <= SOBE;
            else if (w_proximo == DESCENDO && r_estado != DESCENDO)
                r_dir_memo <= DESCE;
        end
    end

    // Moore output decode from the state register (plus floor-0 test in EMERG).
    always_comb begin
        bus.motor_liga    = 1'b0;
        bus.motor_direcao = 1'b0;
        bus.porta_aberta  = 1'b0;
        case (r_estado)
            SUBINDO: begin
                bus.motor_liga    = 1'b1;
                bus.motor_direcao = SOBE;
            end
            DESCENDO: begin
                bus.motor_liga    = 1'b1;
                bus.motor_direcao = DESCE;
            end
            PORTA: bus.porta_aberta = 1'b1;
            EMERG: begin
                if (!w_base) bus.motor_liga   = 1'b1;
                else         bus.porta_aberta = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.led_estado = r_estado;
    assign bus.pendentes  = r_pendentes;
endmodule

// File: tb/tb_elevador_fila.sv
// Bench for elevador_fila: directed scenarios with literal expectations
// and a randomized run against a behavioural elevator model.
module tb_elevador_fila;
    localparam int N     = 5;
    localparam int TEMPO = 4;
    localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3, M_EMERG = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   g_floor = 0;
    bit   g_emerg = 1'b0;

    // Behavioural model: what the cab is doing, which calls are waiting,
    // last travel direction and how many door-open cycles remain.
    int m_mode;
    bit m_pend[N];
    bit m_last_up;
    int m_door_left;

    elevador_fila_if #(.N_ANDARES(N)) bus();

    elevador_fila #(.N_ANDARES(N), .TEMPO_PORTA(TEMPO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Observation vector {liga, dir, porta, led[2:0], pendentes[4:0]}.
    function automatic logic [10:0] dut_out();
        return {bus.motor_liga, bus.motor_direcao, bus.porta_aberta, bus.led_estado, bus.pendentes};
    endfunction

    function automatic logic [10:0] model_out(input int f);
        logic       liga, dir, porta;
        logic [N-1:0] pv;
        liga  = (m_mode == M_UP) || (m_mode == M_DOWN) || (m_mode == M_EMERG && f != 0);
        dir   = (m_mode == M_UP);
        porta = (m_mode == M_DOOR) || (m_mode == M_EMERG && f == 0);
        for (int i = 0; i < N; i++) pv[i] = m_pend[i];
        return {liga, dir, porta, 3'(m_mode), pv};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_last_up = 1'b1;
        m_door_left = 0;
    endtask

    task automatic model_update(input bit e, input int f, input bit pv, input int req);
        bit here, above, below;
        int nm;
        bit np[N];
        here  = (f < N) && m_pend[f];
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && i > f) above = 1'b1;
            if (m_pend[i] && i < f) below = 1'b1;
        end
        np = m_pend;
        nm = m_mode;
        if (e) begin
            nm = M_EMERG;
            for (int i = 0; i < N; i++) np[i] = 1'b0;
        end else begin
            if (m_mode == M_EMERG) begin
                nm = M_IDLE;
            end else if (m_mode == M_DOOR) begin
                if (pv && req == f)        m_door_left = TEMPO;
                else if (m_door_left == 1) nm = M_IDLE;
                else                       m_door_left--;
            end else if (here) begin
                nm = M_DOOR;
                m_door_left = TEMPO;
            end else if (m_mode == M_IDLE) begin
                if (above && below) nm = m_last_up ? M_UP : M_DOWN;
                else if (above)     nm = M_UP;
                else if (below)     nm = M_DOWN;
            end else if (m_mode == M_UP) begin
                if (!above || f >= N - 1) nm = M_IDLE;
            end else begin
                if (!below || f == 0) nm = M_IDLE;
            end
            if (pv && req < N && m_mode != M_EMERG && !(m_mode == M_DOOR && req == f))
                np[req] = 1'b1;
            if (nm == M_DOOR && m_mode != M_DOOR) np[f] = 1'b0;
        end
        if (nm == M_UP)   m_last_up = 1'b1;
        if (nm == M_DOWN) m_last_up = 1'b0;
        m_mode = nm;
        m_pend = np;
    endtask

    // Drive one cycle of inputs (from a negedge), advance, land on next negedge.
    task automatic step(input bit pv, input int req);
        bus.emergencia    = g_emerg;
        bus.andar_atual   = 3'(g_floor);
        bus.pedido_valido = pv;
        bus.andar_pedido  = 3'(req);
        model_update(g_emerg, g_floor, pv, req);
        @(posedge clock);
        @(negedge clock);
        bus.pedido_valido = 1'b0;
    endtask

    task automatic do_reset(input int f);
        reset_n = 1'b0;
        g_floor = f;
        g_emerg = 1'b0;
        bus.emergencia    = 1'b0;
        bus.andar_atual   = 3'(f);
        bus.pedido_valido = 1'b0;
        bus.andar_pedido  = '0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(0);
        step(1, 2);
        step(1, 4);
        checks++;
        if (dut_out() !== {1'b1, 1'b1, 1'b0, 3'd1, 5'b10100}) begin
            failures++;
            $display("FAIL reset_pre: got %b expected %b", dut_out(), {1'b1, 1'b1, 1'b0, 3'd1, 5'b10100});
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (dut_out() !== 11'b0) begin
            failures++;
            $display("FAIL reset_async: got %b expected %b", dut_out(), 11'b0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_request();
        do_reset(0);
        step(1, 3);
        checks++;
        if (dut_out() !== {1'b0, 1'b0, 1'b0, 3'd0, 5'b01000}) begin
            failures++;
            $display("FAIL single_latch: got %b expected %b", dut_out(), {1'b0, 1'b0, 1'b0, 3'd0, 5'b01000});
        end
        step(0, 0);
        checks++;
        if (dut_out() !== {1'b1, 1'b1, 1'b0, 3'd1, 5'b01000}) begin
            failures++;
            $display("FAIL single_motor: got %b expected %b", dut_out(), {1'b1, 1'b1, 1'b0, 3'd1, 5'b01000});
        end
        g_floor = 1; step(0, 0);
        g_floor = 2; step(0, 0);
        g_floor = 3; step(0, 0);
        for (int k = 0; k < TEMPO; k++) begin
            checks++;
            if (dut_out() !== {1'b0, 1'b0, 1'b1, 3'd3, 5'b00000}) begin
                failures++;
                $display("FAIL single_door_c%0d: got %b expected %b", k, dut_out(), {1'b0, 1'b0, 1'b1, 3'd3, 5'b00000});
            end
            step(0, 0);
        end
        checks++;
        if (dut_out() !== 11'b0) begin
            failures++;
            $display("FAIL single_closed: got %b expected %b", dut_out(), 11'b0);
        end
    endtask

    task automatic test_scan();
        do_reset(2);
        step(1, 2);
        step(0, 0);
        step(1, 4);
        step(1, 0);
        checks++;
        if (dut_out() !== {1'b0, 1'b0, 1'b1, 3'd3, 5'b10001}) begin
            failures++;
            $display("FAIL scan_latch: got %b expected %b", dut_out(), {1'b0, 1'b0, 1'b1, 3'd3, 5'b10001});
        end
        step(0, 0);
        step(0, 0);
        step(0, 0);
        checks++;
        if (dut_out() !== {1'b1, 1'b1, 1'b0, 3'd1, 5'b10001}) begin
            failures++;
            $display("FAIL scan_up_first: got %b expected %b", dut_out(), {1'b1, 1'b1, 1'b0, 3'd1, 5'b10001});
        end
        g_floor = 3; step(0, 0);
        g_floor = 4; step(0, 0);
        checks++;
        if (dut_out() !== {1'b0, 1'b0, 1'b1, 3'd3, 5'b00001}) begin
            failures++;
            $display("FAIL scan_serve4: got %b expected %b", dut_out(), {1'b0, 1'b0, 1'b1, 3'd3, 5'b00001});
        end
        for (int k = 0; k < TEMPO + 1; k++) step(0, 0);
        checks++;
        if (dut_out() !== {1'b1, 1'b0, 1'b0, 3'd2, 5'b00001}) begin
            failures++;
            $display("FAIL scan_down: got %b expected %b", dut_out(), {1'b1, 1'b0, 1'b0, 3'd2, 5'b00001});
        end
        for (int f = 3; f >= 0; f--) begin
            g_floor = f;
            step(0, 0);
        end
        checks++;
        if (dut_out() !== {1'b0, 1'b0, 1'b1, 3'd3, 5'b00000}) begin
            failures++;
            $display("FAIL scan_serve0: got %b expected %b", dut_out(), {1'b0, 1'b0, 1'b1, 3'd3, 5'b00000});
        end
    endtask

    task automatic test_door_hold();
        do_reset(1);
        step(1, 1);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        step(1, 1);
        for (int k = 0; k < TEMPO; k++) begin
            checks++;
            if (dut_out() !== {1'b0, 1'b0, 1'b1, 3'd3, 5'b00000}) begin
                failures++;
                $display("FAIL hold_open_c%0d: got %b expected %b", k, dut_out(), {1'b0, 1'b0, 1'b1, 3'd3, 5'b00000});
            end
            step(0, 0);
        end
        checks++;
        if (dut_out() !== 11'b0) begin
            failures++;
            $display("FAIL hold_closed: got %b expected %b", dut_out(), 11'b0);
        end
    endtask

    task automatic test_emergency();
        do_reset(3);
        step(1, 4);
        step(0, 0);
        checks++;
        if (dut_out() !== {1'b1, 1'b1, 1'b0, 3'd1, 5'b10000}) begin
            failures++;
            $display("FAIL emerg_pre: got %b expected %b", dut_out(), {1'b1, 1'b1, 1'b0, 3'd1, 5'b10000});
        end
        g_emerg = 1'b1;
        step(0, 0);
        checks++;
        if (dut_out() !== {1'b1, 1'b0, 1'b0, 3'd4, 5'b00000}) begin
            failures++;
            $display("FAIL emerg_enter: got %b expected %b", dut_out(), {1'b1, 1'b0, 1'b0, 3'd4, 5'b00000});
        end
        g_floor = 2; step(1, 3);
        checks++;
        if (dut_out() !== {1'b1, 1'b0, 1'b0, 3'd4, 5'b00000}) begin
            failures++;
            $display("FAIL emerg_ignore_req: got %b expected %b", dut_out(), {1'b1, 1'b0, 1'b0, 3'd4, 5'b00000});
        end
        g_floor = 1; step(0, 0);
        g_floor = 0; step(0, 0);
        checks++;
        if (dut_out() !== {1'b0, 1'b0, 1'b1, 3'd4, 5'b00000}) begin
            failures++;
            $display("FAIL emerg_floor0: got %b expected %b", dut_out(), {1'b0, 1'b0, 1'b1, 3'd4, 5'b00000});
        end
        g_emerg = 1'b0;
        step(0, 0);
        checks++;
        if (dut_out() !== 11'b0) begin
            failures++;
            $display("FAIL emerg_release: got %b expected %b", dut_out(), 11'b0);
        end
    endtask

    task automatic test_out_of_range();
        do_reset(0);
        step(1, 6);
        step(1, 5);
        checks++;
        if (dut_out() !== 11'b0) begin
            failures++;
            $display("FAIL oor_idle: got %b expected %b", dut_out(), 11'b0);
        end
        do_reset(1);
        step(1, 1);
        step(0, 0);
        step(1, 3);
        step(1, 6);
        checks++;
        if (dut_out() !== {1'b0, 1'b0, 1'b1, 3'd3, 5'b01000}) begin
            failures++;
            $display("FAIL oor_door6: got %b expected %b", dut_out(), {1'b0, 1'b0, 1'b1, 3'd3, 5'b01000});
        end
        step(1, 7);
        checks++;
        if (dut_out() !== {1'b0, 1'b0, 1'b1, 3'd3, 5'b01000}) begin
            failures++;
            $display("FAIL oor_door7: got %b expected %b", dut_out(), {1'b0, 1'b0, 1'b1, 3'd3, 5'b01000});
        end
    endtask

    task automatic test_random();
        logic [10:0] exp_v;
        do_reset($urandom_range(0, N - 1));
        for (int c = 0; c < 1500; c++) begin
            exp_v = model_out(g_floor);
            if (exp_v[10] && $urandom_range(0, 2) == 0) begin
                if (exp_v[9] && g_floor < N - 1) g_floor++;
                else if (!exp_v[9] && g_floor > 0) g_floor--;
            end
            if (!g_emerg && $urandom_range(0, 119) == 0) g_emerg = 1'b1;
            else if (g_emerg && $urandom_range(0, 24) == 0) g_emerg = 1'b0;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 7));
            checks++;
            if (dut_out() !== model_out(g_floor)) begin
                failures++;
                $display("FAIL random_c%0d: got %b expected %b", c, dut_out(), model_out(g_floor));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_request();
        test_scan();
        test_door_hold();
        test_emergency();
        test_out_of_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/elevador_fila.md
Name: elevador_fila

Overview:
- Parametrised multi-floor elevator controller: N_ANDARES floors, a latched request queue (one bit per floor) and SCAN-style direction selection.
- Adds a timed door-open phase and a latched emergency descent mode.
- Sits between the floor sensor and call-button logic and the motor/door drivers.
- Drop-in successor to the single-request controller; it keeps the motor_liga, motor_direcao and state-LED output style.

Parameters:
- N_ANDARES, 5, number of floors (floors 0..N_ANDARES-1); minimum 2.
- LARGURA_ANDAR, $clog2(N_ANDARES), width of floor-number buses.
- TEMPO_PORTA, 4, door-open duration in clock cycles; minimum 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- emergencia  in  1  level input: while high, controller descends to floor 0 and holds.
- andar_atual  in  LARGURA_ANDAR  floor sensor reading, already synchronised.
- pedido_valido  in  1  one-cycle strobe: andar_pedido is a new request.
- andar_pedido  in  LARGURA_ANDAR  requested floor.
- motor_liga  out  1  motor enable.
- motor_direcao  out  1  1 = up, 0 = down; 0 when motor off.
- porta_aberta  out  1  door-open command.
- pendentes  out  N_ANDARES  request register; bit i = floor i pending.
- led_estado  out  3  current state encoding.

Behaviour:
- Reset (reset_n low, asynchronous):
  - estado=PARADO, pendentes=0, timer=0, dir_memo=up.
  - Outputs: motor_liga=0, motor_direcao=0, porta_aberta=0, led_estado=0.
  - Reset mid-travel drops all requests immediately; no completion.
- States (3-bit): PARADO=0, SUBINDO=1, DESCENDO=2, PORTA=3, EMERG=4. Codes 5..7 return to PARADO at the next edge.
- Outputs are Moore, decoded from the state register only:
  - SUBINDO: liga=1, dir=1.
  - DESCENDO: liga=1, dir=0.
  - EMERG with andar_atual!=0: liga=1, dir=0.
  - EMERG at floor 0: liga=0, porta_aberta=1.
  - PORTA: porta_aberta=1.
  - All other cases: all outputs 0.
  - led_estado = estado.
- Request latch:
  - pedido_valido with andar_pedido < N_ANDARES sets pendentes[andar_pedido] at the next edge. Out-of-range requests are ignored.
  - A request equal to andar_atual while in PORTA is not latched; it reloads the door timer (door-hold).
  - A set and a clear of the same bit in the same cycle: clear wins.
- Latency: strobe at cycle n -> pendentes visible at n+1 -> estado changes at the edge ending n+1 -> motor_liga=1 during n+2.
- PARADO:
  - pendentes[andar_atual] -> PORTA.
  - Else: requests both above and below -> direction per dir_memo.
  - Else: only above -> SUBINDO; only below -> DESCENDO.
  - Else stay in PARADO.
- SUBINDO, and DESCENDO symmetrically:
  - pendentes[andar_atual] -> PORTA; that bit clears on the same edge.
  - Else, no requests remaining ahead in the current direction -> PARADO.
  - andar_atual==N_ANDARES-1 while SUBINDO, or 0 while DESCENDO -> PARADO (end-stop guard).
  - dir_memo updates on entry to SUBINDO or DESCENDO.
- PORTA:
  - Timer loads TEMPO_PORTA-1 on entry and decrements each cycle.
  - At 0 -> PARADO, so the door is open exactly TEMPO_PORTA cycles absent a door-hold.
  - Entry into PORTA clears pendentes[andar_atual].
- Emergency (highest priority, any state):
  - emergencia=1 -> EMERG at the next edge; pendentes cleared; new requests ignored while in EMERG.
  - In EMERG: descend until andar_atual==0, then motor off and door open.
  - emergencia=0 -> PARADO at the next edge, from any floor.
- andar_atual >= N_ANDARES is treated as no floor match; the end-stop guard still applies.

Decomposition:
- Package elevador_pkg holds:
  - the state encodings above;
  - the direction constants SOBE=1 and DESCE=0;
  - a function that computes has_above/has_below from pendentes and andar_atual.
- Sub-module temporizador_porta:
  - TEMPO_PORTA-bounded down-counter with load, reload and expira ports.
  - Instantiated once.
- The FSM and the request register stay in the top module.

Test Plan (N_ANDARES=5, TEMPO_PORTA=4):
- Reset while SUBINDO with pendentes=5'b10100 -> all outputs 0, pendentes=0, led_estado=0, immediately after reset_n falls.
- At floor 0, request floor 3 at cycle n:
  - pendentes=5'b01000 at n+1; motor_liga=1, motor_direcao=1 from n+2.
  - Sensor reaches 3 -> next cycle porta_aberta=1 for 4 cycles, pendentes=0, then led_estado=0.
- At floor 2 with dir_memo=up, requests 4 and 0 -> goes SUBINDO first; serves 4, door open, then DESCENDO to serve 0.
- In PORTA at floor 1, re-request floor 1 on the 3rd open cycle -> door stays open 4 more cycles; pendentes[1] stays 0.
- Emergency asserted at floor 3 while SUBINDO with pendentes=5'b10000 -> led_estado=4, dir=0, liga=1, pendentes=0.
  - At floor 0: liga=0, porta_aberta=1.
  - emergencia deasserted -> PARADO the next cycle.
- Request andar_pedido=6 (out of range) -> pendentes unchanged, state unchanged.
